// File: rtl/adpll_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// adpll_pkg: types and constants shared by the ADPLL front end, loop filter and DCO controller. Rev 1.0
// ----------------------------------------------------------------------------
package adpll_pkg;

  localparam int   DLF_IO_W = 8;
  localparam logic LEAD_FB  = 1'b1;
  localparam logic LEAD_REF = 1'b0;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    REF_FIRST = 2'd1,
    FB_FIRST  = 2'd2
  } pe_state_t;

endpackage
`default_nettype wire

// File: rtl/adpll_phase_error_counter_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// adpll_phase_error_counter_if: clock inputs and error/status outputs of the phase error counter. Rev 1.0
// ----------------------------------------------------------------------------
interface adpll_phase_error_counter_if #(
  parameter int MAG_W = 8
);

  logic             ref_in;
  logic             fb_in;
  logic [MAG_W-1:0] err_mag;
  logic             lead;
  logic             err_valid;
  logic             slip;
  logic             timeout;

  modport master (
    input  ref_in, fb_in,
    output err_mag, lead, err_valid, slip, timeout
  );

  modport slave (
    output ref_in, fb_in,
    input  err_mag, lead, err_valid, slip, timeout
  );

endinterface
`default_nettype wire

// File: rtl/adpll_edge_sync.sv
`default_nettype none
// ----------------------------------------------------------------------------
// adpll_edge_sync: multi-flop synchroniser followed by a rising-edge pulse. Rev 1.0
// ----------------------------------------------------------------------------
module adpll_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  wire logic clk,
  input  wire logic rstn,
  input  wire logic async_in,
  output logic      rise
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_d;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync_q <= '0;
      sync_d <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
      sync_d <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise = sync_q[SYNC_STAGES-1] & ~sync_d;

endmodule
`default_nettype wire

// File: rtl/adpll_phase_error_counter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// adpll_phase_error_counter: ref/fb edge-to-edge distance in clk cycles, with slip and timeout flags. Rev 1.0
// ----------------------------------------------------------------------------
module adpll_phase_error_counter
  import adpll_pkg::*;
#(
  parameter int MAG_W       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT_CYC = 1023
) (
  input  wire logic                   clk,
  input  wire logic                   rstn,
  adpll_phase_error_counter_if.master pe
);

  localparam int               CNT_W   = $clog2(TIMEOUT_CYC + 1);
  localparam logic [MAG_W-1:0] MAG_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_TMO = CNT_W'(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic             ref_rise;
  logic             fb_rise;
  pe_state_t        state;
  logic [CNT_W-1:0] cnt;
  logic [MAG_W-1:0] err_mag_q;
  logic             lead_q;
  logic             err_valid_q;
  logic             slip_q;
  logic             timeout_q;

  function automatic logic [MAG_W-1:0] sat(input logic [CNT_W-1:0] x);
    if (32'(x) > 32'(MAG_MAX)) return MAG_MAX;
    return MAG_W'(x);
  endfunction

  adpll_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_ref_sync (
    .clk      (clk),
    .rstn     (rstn),
    .async_in (pe.ref_in),
    .rise     (ref_rise)
  );

  adpll_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_fb_sync (
    .clk      (clk),
    .rstn     (rstn),
    .async_in (pe.fb_in),
    .rise     (fb_rise)
  );

  // Partner edge wins over a same-side repeat, and any edge wins over timeout.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= IDLE;
      cnt         <= '0;
      err_mag_q   <= '0;
      lead_q      <= LEAD_FB;
      err_valid_q <= 1'b0;
      slip_q      <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      err_valid_q <= 1'b0;
      slip_q      <= 1'b0;
      timeout_q   <= 1'b0;
      case (state)
        IDLE: begin
          if (ref_rise && fb_rise) begin
            err_mag_q   <= '0;
            lead_q      <= LEAD_FB;
            err_valid_q <= 1'b1;
          end else if (ref_rise) begin
            state <= REF_FIRST;
            cnt   <= CNT_ONE;
          end else if (fb_rise) begin
            state <= FB_FIRST;
            cnt   <= CNT_ONE;
          end
        end
        REF_FIRST: begin
          if (fb_rise) begin
            err_mag_q   <= sat(cnt);
            lead_q      <= LEAD_REF;
            err_valid_q <= 1'b1;
            if (ref_rise) cnt <= CNT_ONE;
            else          state <= IDLE;
          end else if (ref_rise) begin
            err_mag_q   <= MAG_MAX;
            lead_q      <= LEAD_REF;
            err_valid_q <= 1'b1;
            slip_q      <= 1'b1;
            cnt         <= CNT_ONE;
          end else if (cnt == CNT_TMO) begin
            err_mag_q   <= MAG_MAX;
            lead_q      <= LEAD_REF;
            err_valid_q <= 1'b1;
            timeout_q   <= 1'b1;
            state       <= IDLE;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        FB_FIRST: begin
          if (ref_rise) begin
            err_mag_q   <= sat(cnt);
            lead_q      <= LEAD_FB;
            err_valid_q <= 1'b1;
            if (fb_rise) cnt <= CNT_ONE;
            else         state <= IDLE;
          end else if (fb_rise) begin
            err_mag_q   <= MAG_MAX;
            lead_q      <= LEAD_FB;
            err_valid_q <= 1'b1;
            slip_q      <= 1'b1;
            cnt         <= CNT_ONE;
          end else if (cnt == CNT_TMO) begin
            err_mag_q   <= MAG_MAX;
            lead_q      <= LEAD_FB;
            err_valid_q <= 1'b1;
            timeout_q   <= 1'b1;
            state       <= IDLE;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  assign pe.err_mag   = err_mag_q;
  assign pe.lead      = lead_q;
  assign pe.err_valid = err_valid_q;
  assign pe.slip      = slip_q;
  assign pe.timeout   = timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_adpll_phase_error_counter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_adpll_phase_error_counter: directed vectors with a queue-based scoreboard. Rev 1.0
// ----------------------------------------------------------------------------
module tb_adpll_phase_error_counter;

  typedef struct packed {
    logic [7:0] mag;
    logic       lead;
    logic       slip;
    logic       tmo;
  } exp_t;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  adpll_phase_error_counter_if #(.MAG_W(8)) pe ();

  adpll_phase_error_counter #(
    .MAG_W       (8),
    .SYNC_STAGES (2),
    .TIMEOUT_CYC (1023)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .pe   (pe.master)
  );

  // Monitor: every err_valid pops one expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rstn && pe.err_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_valid got mag=%0d lead=%0d slip=%0d tmo=%0d, none expected",
                 pe.err_mag, pe.lead, pe.slip, pe.timeout);
      end else begin
        e = exp_q.pop_front();
        if (pe.err_mag !== e.mag || pe.lead !== e.lead || pe.slip !== e.slip || pe.timeout !== e.tmo) begin
          failures++;
          $display("FAIL publish got mag=%0d lead=%0d slip=%0d tmo=%0d, want mag=%0d lead=%0d slip=%0d tmo=%0d",
                   pe.err_mag, pe.lead, pe.slip, pe.timeout, e.mag, e.lead, e.slip, e.tmo);
        end
      end
    end else if (rstn && (pe.slip || pe.timeout)) begin
      checks++;
      failures++;
      $display("FAIL flag_without_valid got slip=%0d tmo=%0d, want 0 0", pe.slip, pe.timeout);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s got %0d want %0d", name, act, want);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_err_mag"},   32'(pe.err_mag),   32'd0);
    chk({tag, "_lead"},      32'(pe.lead),      32'd1);
    chk({tag, "_err_valid"}, 32'(pe.err_valid), 32'd0);
    chk({tag, "_slip"},      32'(pe.slip),      32'd0);
    chk({tag, "_timeout"},   32'(pe.timeout),   32'd0);
  endtask

  // One leading edge, partner edge k cycles later (k=0: simultaneous).
  task automatic pair(input bit ref_first, input int k, input exp_t e);
    @(negedge clk);
    if (k == 0) begin
      pe.ref_in = 1'b1;
      pe.fb_in  = 1'b1;
      exp_q.push_back(e);
    end else begin
      if (ref_first) pe.ref_in = 1'b1; else pe.fb_in = 1'b1;
      idle(k);
      if (ref_first) pe.fb_in = 1'b1; else pe.ref_in = 1'b1;
      exp_q.push_back(e);
    end
    idle(4);
    pe.ref_in = 1'b0;
    pe.fb_in  = 1'b0;
    idle(10);
  endtask

  initial begin
    int w;
    pe.ref_in = 1'b0;
    pe.fb_in  = 1'b0;
    idle(3);
    check_reset_values("reset");
    rstn = 1'b1;
    idle(5);

    pair(1'b1, 5,    '{mag: 8'd5,   lead: 1'b0, slip: 1'b0, tmo: 1'b0});
    pair(1'b0, 12,   '{mag: 8'd12,  lead: 1'b1, slip: 1'b0, tmo: 1'b0});
    pair(1'b1, 0,    '{mag: 8'd0,   lead: 1'b1, slip: 1'b0, tmo: 1'b0});
    pair(1'b1, 300,  '{mag: 8'd255, lead: 1'b0, slip: 1'b0, tmo: 1'b0});
    pair(1'b1, 254,  '{mag: 8'd254, lead: 1'b0, slip: 1'b0, tmo: 1'b0});
    pair(1'b1, 255,  '{mag: 8'd255, lead: 1'b0, slip: 1'b0, tmo: 1'b0});
    pair(1'b0, 1,    '{mag: 8'd1,   lead: 1'b1, slip: 1'b0, tmo: 1'b0});
    pair(1'b1, 1023, '{mag: 8'd255, lead: 1'b0, slip: 1'b0, tmo: 1'b0});

    // ref slip: ref, ref +40, fb +7
    @(negedge clk);
    pe.ref_in = 1'b1; idle(3); pe.ref_in = 1'b0; idle(37);
    pe.ref_in = 1'b1;
    exp_q.push_back('{mag: 8'd255, lead: 1'b0, slip: 1'b1, tmo: 1'b0});
    idle(7);
    pe.fb_in = 1'b1;
    exp_q.push_back('{mag: 8'd7, lead: 1'b0, slip: 1'b0, tmo: 1'b0});
    idle(4); pe.ref_in = 1'b0; pe.fb_in = 1'b0; idle(10);

    // fb slip: fb, fb +20, ref +9
    pe.fb_in = 1'b1; idle(3); pe.fb_in = 1'b0; idle(17);
    pe.fb_in = 1'b1;
    exp_q.push_back('{mag: 8'd255, lead: 1'b1, slip: 1'b1, tmo: 1'b0});
    idle(9);
    pe.ref_in = 1'b1;
    exp_q.push_back('{mag: 8'd9, lead: 1'b1, slip: 1'b0, tmo: 1'b0});
    idle(4); pe.ref_in = 1'b0; pe.fb_in = 1'b0; idle(10);

    // partner and repeat together: publish 6, then restart and measure 4
    pe.ref_in = 1'b1; idle(3); pe.ref_in = 1'b0; idle(3);
    pe.ref_in = 1'b1; pe.fb_in = 1'b1;
    exp_q.push_back('{mag: 8'd6, lead: 1'b0, slip: 1'b0, tmo: 1'b0});
    idle(2); pe.fb_in = 1'b0; idle(2);
    pe.fb_in = 1'b1;
    exp_q.push_back('{mag: 8'd4, lead: 1'b0, slip: 1'b0, tmo: 1'b0});
    idle(4); pe.ref_in = 1'b0; pe.fb_in = 1'b0; idle(10);

    // timeout, then a normal fb-leads measurement proves the FSM is back in IDLE
    pe.ref_in = 1'b1;
    exp_q.push_back('{mag: 8'd255, lead: 1'b0, slip: 1'b0, tmo: 1'b1});
    idle(1035);
    pe.ref_in = 1'b0;
    idle(10);
    pair(1'b0, 3, '{mag: 8'd3, lead: 1'b1, slip: 1'b0, tmo: 1'b0});

    // reset mid-measurement: the aborted count must never publish
    pe.ref_in = 1'b1; idle(10); pe.ref_in = 1'b0; idle(5);
    rstn = 1'b0;
    idle(2);
    check_reset_values("midreset");
    rstn = 1'b1;
    idle(1100);
    check_reset_values("postreset");
    pair(1'b1, 9, '{mag: 8'd9, lead: 1'b0, slip: 1'b0, tmo: 1'b0});

    w = 0;
    while (exp_q.size() != 0 && w < 50) begin
      idle(1);
      w++;
    end
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
